// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// branch redirect inputs and the instruction handshake towards decode.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pc_src;
    logic [31:0] branch_pc;
    logic [31:0] imm_ext;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        output instr_valid, instr, instr_pc, instr_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  pc_src, branch_pc, imm_ext, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  instr_valid, instr, instr_pc, instr_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output pc_src, branch_pc, imm_ext, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: PC register, credit-limited request issue, in-order
// response queue and branch redirect with stale-response draining.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]      r_rsp_pc, w_rsp_pc_nxt;
    logic [31:0]      r_pend_addr;
    logic             r_pend, w_pend_nxt;
    logic [CNT_W-1:0] r_inflight, w_inflight_nxt;
    logic [CNT_W-1:0] r_occ, w_occ_nxt;
    logic [CNT_W-1:0] r_drop_cnt, w_drop_nxt;
    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [31:0]      r_q_data [DEPTH];
    logic [31:0]      r_q_pc   [DEPTH];

    logic             w_head_valid;
    logic             w_credit;
    logic             w_accept;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W:0]   w_used;
    logic [31:0]      w_target;
    logic [31:0]      w_head_data;
    logic [31:0]      w_head_pc;

    function automatic logic [31:0] f_target(input logic [31:0] pc, input logic [31:0] off);
        logic [31:0] sum;
        sum = pc + off;
        return {sum[31:2], 2'b00};
    endfunction

    // Credit uses registered counts only, so a pop never frees a slot in the same cycle.
    assign w_used       = {1'b0, r_inflight} + {1'b0, r_occ};
    assign w_credit     = (w_used < DEPTH_C);
    assign w_head_valid = (r_occ != '0);
    assign w_target     = f_target(bus.branch_pc, bus.imm_ext);

    // A request left pending keeps its original address even after a redirect.
    assign bus.imem_req_valid = r_pend || ((r_state == FETCH) && w_credit);
    assign bus.imem_req_addr  = r_pend ? r_pend_addr : r_fetch_pc;

    assign w_accept = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rsp    = bus.imem_rsp_valid && (r_state != IDLE);
    assign w_push   = (r_state == FETCH) && w_rsp && !bus.pc_src;
    assign w_pop    = w_head_valid && bus.instr_ready;

    assign w_head_data = r_q_data[r_rd_ptr];
    assign w_head_pc   = r_q_pc[r_rd_ptr];

    assign bus.instr_valid    = w_head_valid;
    assign bus.instr          = w_head_valid ? w_head_data : 32'h0;
    assign bus.instr_pc       = w_head_valid ? w_head_pc : 32'h0;
    assign bus.instr_pc_plus4 = w_head_valid ? (w_head_pc + 32'd4) : 32'h0;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_rsp_pc_nxt   = r_rsp_pc;
        w_drop_nxt     = r_drop_cnt;
        w_pend_nxt     = bus.imem_req_valid && !bus.imem_req_ready;
        w_inflight_nxt = r_inflight + CNT_W'(w_accept) - CNT_W'(w_rsp);

        if (bus.pc_src) begin
            w_fetch_pc_nxt = w_target;
            w_rsp_pc_nxt   = w_target;
        end

        unique case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.pc_src) begin
                    // Everything in flight, plus a still-pending request, belongs to the old stream.
                    w_drop_nxt = w_inflight_nxt;
                    if ((w_inflight_nxt != '0) || w_pend_nxt) begin
                        w_state_nxt = FLUSH;
                    end
                end else begin
                    if (w_accept) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    if (w_push)   w_rsp_pc_nxt   = r_rsp_pc + 32'd4;
                end
            end
            FLUSH: begin
                w_drop_nxt = r_drop_cnt + CNT_W'(w_accept) - CNT_W'(w_rsp);
                if ((w_drop_nxt == '0) && !w_pend_nxt) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_occ_nxt    = r_occ;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (bus.pc_src) begin
            w_occ_nxt    = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            w_occ_nxt    = r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_pend     <= 1'b0;
            r_inflight <= '0;
            r_occ      <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_rsp_pc   <= w_rsp_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_inflight <= w_inflight_nxt;
            r_occ      <= w_occ_nxt;
            r_drop_cnt <= w_drop_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
        end
    end

    // Data-only storage: validity is carried entirely by the counters above.
    always_ff @(posedge clk) begin
        if (w_pend_nxt) begin
            r_pend_addr <= bus.imem_req_addr;
        end
        if (w_push) begin
            r_q_data[r_wr_ptr] <= bus.imem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency in-order
// instruction memory whose word at address a is a + DATA_OFS.
module tb_instr_fetch_unit;
    localparam logic [31:0] DATA_OFS = 32'h1000_0013;

    logic clk;
    logic rst;
    bit   rsp_en;
    int   n_assert;
    int   n_fail;
    logic [31:0] mq [$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: accepted addresses queue up and return one cycle later.
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
        end else begin
            if (bus.imem_rsp_valid === 1'b1) void'(mq.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) mq.push_back(bus.imem_req_addr);
        end
    end

    always @(negedge clk) begin
        #1;
        bus.imem_rsp_valid = rsp_en && (mq.size() != 0);
        bus.imem_rsp_data  = (mq.size() != 0) ? (mq[0] + DATA_OFS) : 32'h0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic reset_on();
        rst = 1'b0;
        rsp_en = 1'b1;
        bus.pc_src = 1'b0;
        bus.branch_pc = 32'h0;
        bus.imm_ext = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
        chk1({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
        chk({tag, "_instr"}, bus.instr, 32'h0);
        chk({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
        chk({tag, "_instr_pc4"}, bus.instr_pc_plus4, 32'h0);
    endtask

    // Waits (bounded) for the head, checks it, then lets it be consumed.
    task automatic expect_instr(input string tag, input logic [31:0] pc);
        int k;
        k = 0;
        while (!bus.instr_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk1({tag, "_valid"}, bus.instr_valid, 1'b1);
        chk({tag, "_pc"}, bus.instr_pc, pc);
        chk({tag, "_pc4"}, bus.instr_pc_plus4, pc + 32'd4);
        chk({tag, "_data"}, bus.instr, pc + DATA_OFS);
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b0;
        rsp_en = 1'b1;
        bus.pc_src = 1'b0;
        bus.branch_pc = 32'h0;
        bus.imm_ext = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clk);

        // Reset release and first fetches
        reset_on();
        chk_reset("rst");
        rst = 1'b1;
        @(negedge clk);
        chk1("s1_req_valid0", bus.imem_req_valid, 1'b1);
        chk("s1_addr0", bus.imem_req_addr, 32'h0);
        @(negedge clk);
        chk1("s1_req_valid1", bus.imem_req_valid, 1'b1);
        chk("s1_addr1", bus.imem_req_addr, 32'h4);
        chk1("s1_no_instr_yet", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s1_instr_valid", bus.instr_valid, 1'b1);
        chk("s1_instr_pc", bus.instr_pc, 32'h0);
        chk("s1_instr_pc4", bus.instr_pc_plus4, 32'h4);
        chk("s1_instr", bus.instr, 32'h1000_0013);
        chk1("s1_credit_full", bus.imem_req_valid, 1'b0);
        @(negedge clk);
        chk("s1_instr_pc_next", bus.instr_pc, 32'h4);
        chk1("s1_req_valid2", bus.imem_req_valid, 1'b1);
        chk("s1_addr2", bus.imem_req_addr, 32'h8);

        // Decode stall: credit limit and stable head
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("s2_stall_req", bus.imem_req_valid, 1'b0);
            chk("s2_stall_pc", bus.instr_pc, 32'h4);
        end
        chk1("s2_stall_valid", bus.instr_valid, 1'b1);
        bus.instr_ready = 1'b1;
        expect_instr("s2_a", 32'h4);
        expect_instr("s2_b", 32'h8);
        expect_instr("s2_c", 32'hC);
        expect_instr("s2_d", 32'h10);

        // Redirect with two requests in flight
        reset_on();
        rsp_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("s3_addr0", bus.imem_req_addr, 32'h0);
        @(negedge clk);
        chk("s3_addr1", bus.imem_req_addr, 32'h4);
        @(negedge clk);
        chk1("s3_two_inflight", bus.imem_req_valid, 1'b0);
        bus.pc_src = 1'b1;
        bus.branch_pc = 32'h10;
        bus.imm_ext = 32'hFFFF_FFF8;
        @(negedge clk);
        bus.pc_src = 1'b0;
        rsp_en = 1'b1;
        chk1("s3_flush_req0", bus.imem_req_valid, 1'b0);
        chk1("s3_flush_iv0", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s3_flush_req1", bus.imem_req_valid, 1'b0);
        chk1("s3_flush_iv1", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s3_target_req", bus.imem_req_valid, 1'b1);
        chk("s3_target_addr", bus.imem_req_addr, 32'h8);
        chk1("s3_flush_iv2", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s3_flush_iv3", bus.instr_valid, 1'b0);
        expect_instr("s3_a", 32'h8);
        expect_instr("s3_b", 32'hC);

        // Redirect coinciding with a response and an accept; target low bits masked
        reset_on();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s4_addr1", bus.imem_req_addr, 32'h4);
        bus.pc_src = 1'b1;
        bus.branch_pc = 32'h100;
        bus.imm_ext = 32'h23;
        @(negedge clk);
        bus.pc_src = 1'b0;
        chk1("s4_flush_req", bus.imem_req_valid, 1'b0);
        chk1("s4_flush_iv0", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s4_target_req", bus.imem_req_valid, 1'b1);
        chk("s4_target_addr", bus.imem_req_addr, 32'h120);
        chk1("s4_flush_iv1", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s4_flush_iv2", bus.instr_valid, 1'b0);
        expect_instr("s4_a", 32'h120);
        expect_instr("s4_b", 32'h124);

        // Redirect while the memory back-pressures the request
        reset_on();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("s5_addr0", bus.imem_req_addr, 32'h0);
        bus.pc_src = 1'b1;
        bus.branch_pc = 32'h200;
        bus.imm_ext = 32'h40;
        @(negedge clk);
        bus.pc_src = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("s5_hold_valid", bus.imem_req_valid, 1'b1);
            chk("s5_hold_addr", bus.imem_req_addr, 32'h0);
            chk1("s5_hold_iv", bus.instr_valid, 1'b0);
            @(negedge clk);
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk1("s5_stale_req", bus.imem_req_valid, 1'b0);
        chk1("s5_stale_iv", bus.instr_valid, 1'b0);
        @(negedge clk);
        chk1("s5_target_req", bus.imem_req_valid, 1'b1);
        chk("s5_target_addr", bus.imem_req_addr, 32'h240);
        expect_instr("s5_a", 32'h240);

        // Address wrap, then reset in mid-stream
        reset_on();
        rst = 1'b1;
        @(negedge clk);
        bus.pc_src = 1'b1;
        bus.branch_pc = 32'hFFFF_FFF0;
        bus.imm_ext = 32'hC;
        @(negedge clk);
        bus.pc_src = 1'b0;
        chk1("s6_flush_req", bus.imem_req_valid, 1'b0);
        @(negedge clk);
        chk("s6_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk1("s6_wrap_req", bus.imem_req_valid, 1'b1);
        chk("s6_addr_wrap", bus.imem_req_addr, 32'h0);
        @(negedge clk);
        chk1("s6_top_valid", bus.instr_valid, 1'b1);
        chk("s6_top_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("s6_top_pc4", bus.instr_pc_plus4, 32'h0);
        chk("s6_top_data", bus.instr, 32'h1000_000F);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("s6_midrst");
        rst = 1'b1;
        @(negedge clk);
        chk1("s6_restart_req", bus.imem_req_valid, 1'b1);
        chk("s6_restart_addr", bus.imem_req_addr, 32'h0);
        expect_instr("s6_restart", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
